// File: rtl/dose_scheduler.sv
// Medication dose scheduler: time-of-day clock, programmable dose slots and a
// dispenser request FSM with an acknowledge timeout counted in seconds.
module dose_scheduler #(
  parameter int NUM_SLOTS     = 3,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ACK_TIMEOUT_S = 300,
  localparam int SW           = $clog2(NUM_SLOTS)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 set_time,
  input  logic [4:0]           set_hours,
  input  logic [5:0]           set_minutes,
  input  logic [5:0]           set_seconds,
  input  logic                 cfg_we,
  input  logic [SW-1:0]        cfg_slot,
  input  logic [4:0]           cfg_hours,
  input  logic [5:0]           cfg_minutes,
  input  logic                 cfg_enable,
  input  logic                 disp_ack,
  input  logic [NUM_SLOTS-1:0] missed_clr,
  output logic [4:0]           hours,
  output logic [5:0]           minutes,
  output logic [5:0]           seconds,
  output logic                 second_pulse,
  output logic                 disp_req,
  output logic [SW-1:0]        disp_slot,
  output logic [NUM_SLOTS-1:0] pending,
  output logic [NUM_SLOTS-1:0] missed,
  output logic [1:0]           dbg_state
);

  localparam int PW = $clog2(TICKS_PER_SEC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [11:0]   TO_LAST    = 12'(ACK_TIMEOUT_S - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DONE = 2'd2} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_run, r_tick;
  logic [PW-1:0]        r_presc;
  logic [4:0]           r_hh;
  logic [5:0]           r_mm, r_ss;
  logic [4:0]           r_slot_hh [NUM_SLOTS];
  logic [5:0]           r_slot_mm [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_slot_en, r_pending, r_missed;
  logic [SW-1:0]        r_slot, w_slot_nxt, w_lowest;
  logic [11:0]          r_to_cnt;
  logic                 w_pulse, w_cfg_ok;
  logic [4:0]           w_ld_hh;
  logic [5:0]           w_ld_mm, w_ld_ss;
  logic [NUM_SLOTS-1:0] w_match, w_dis, w_cur, w_avail, w_fsm_clr, w_fsm_miss;

  // r_run is a one-flop release synchroniser: the prescaler first advances on
  // the second rising edge after reset deassertion.
  assign w_pulse  = r_run && !set_time && (r_presc == PRESC_LAST);
  assign w_ld_hh  = (set_hours   > 5'd23) ? 5'd23 : set_hours;
  assign w_ld_mm  = (set_minutes > 6'd59) ? 6'd59 : set_minutes;
  assign w_ld_ss  = (set_seconds > 6'd59) ? 6'd59 : set_seconds;
  assign w_cfg_ok = cfg_we && (int'(cfg_slot) < NUM_SLOTS) &&
                    (cfg_hours <= 5'd23) && (cfg_minutes <= 6'd59);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_run   <= 1'b0;
      r_tick  <= 1'b0;
      r_presc <= '0;
      r_hh    <= '0;
      r_mm    <= '0;
      r_ss    <= '0;
    end else begin
      r_run  <= 1'b1;
      r_tick <= w_pulse;
      if (set_time) begin
        r_presc <= '0;
        r_hh    <= w_ld_hh;
        r_mm    <= w_ld_mm;
        r_ss    <= w_ld_ss;
      end else if (r_run) begin
        if (w_pulse) begin
          r_presc <= '0;
          if (r_ss == 6'd59) begin
            r_ss <= '0;
            if (r_mm == 6'd59) begin
              r_mm <= '0;
              r_hh <= (r_hh == 5'd23) ? 5'd0 : r_hh + 5'd1;
            end else begin
              r_mm <= r_mm + 6'd1;
            end
          end else begin
            r_ss <= r_ss + 6'd1;
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slot_hh[i] <= '0;
        r_slot_mm[i] <= '0;
      end
      r_slot_en <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_cfg_ok && (cfg_slot == SW'(i))) begin
          r_slot_hh[i] <= cfg_hours;
          r_slot_mm[i] <= cfg_minutes;
          r_slot_en[i] <= cfg_enable;
        end
      end
    end
  end

  // A match is only possible in the cycle right after the tick that rolled seconds to 0.
  always_comb begin
    w_match  = '0;
    w_dis    = '0;
    w_cur    = '0;
    w_lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_match[i] = r_tick && !set_time && r_slot_en[i] && (r_ss == 6'd0) &&
                   (r_hh == r_slot_hh[i]) && (r_mm == r_slot_mm[i]);
      w_dis[i]   = w_cfg_ok && !cfg_enable && (cfg_slot == SW'(i));
      w_cur[i]   = (r_slot == SW'(i));
      if (r_pending[i] && !w_dis[i]) w_lowest = SW'(i);
    end
  end

  assign w_avail = r_pending & ~w_dis;

  // Handshake: disp_req stays high with disp_slot frozen until disp_ack (only
  // sampled while disp_req=1), the timeout, or the served slot being disabled.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_fsm_clr   = '0;
    w_fsm_miss  = '0;
    case (r_state)
      ST_IDLE: begin
        if (|w_avail) begin
          w_slot_nxt  = w_lowest;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (disp_ack || |(w_dis & w_cur)) begin
          w_fsm_clr   = w_cur;
          w_state_nxt = ST_DONE;
        end else if (w_pulse && (r_to_cnt == TO_LAST)) begin
          w_fsm_clr   = w_cur;
          w_fsm_miss  = w_cur;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_to_cnt  <= '0;
      r_pending <= '0;
      r_missed  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_slot    <= w_slot_nxt;
      if (r_state != ST_REQ) r_to_cnt <= '0;
      else if (w_pulse)      r_to_cnt <= r_to_cnt + 12'd1;
      r_pending <= (r_pending & ~(w_fsm_clr | w_dis)) | (w_match & ~w_dis);
      r_missed  <= (r_missed & ~missed_clr) | w_fsm_miss | (w_match & r_pending);
    end
  end

  assign hours        = r_hh;
  assign minutes      = r_mm;
  assign seconds      = r_ss;
  assign second_pulse = w_pulse;
  assign disp_req     = (r_state == ST_REQ);
  assign disp_slot    = r_slot;
  assign pending      = r_pending;
  assign missed       = r_missed;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_dose_scheduler.sv
// Bench for dose_scheduler: directed scenarios plus randomized rounds, checked
// every cycle against a seconds-of-day reference model of the scheduler.
module tb_dose_scheduler;

  localparam int N = 3;
  localparam int T = 4;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         set_time;
  logic [4:0]   set_hours;
  logic [5:0]   set_minutes, set_seconds;
  logic         cfg_we;
  logic [1:0]   cfg_slot;
  logic [4:0]   cfg_hours;
  logic [5:0]   cfg_minutes;
  logic         cfg_enable;
  logic         disp_ack;
  logic [N-1:0] missed_clr;
  logic [4:0]   hours;
  logic [5:0]   minutes, seconds;
  logic         second_pulse, disp_req;
  logic [1:0]   disp_slot;
  logic [N-1:0] pending, missed;
  logic [1:0]   dbg_state;

  dose_scheduler #(.NUM_SLOTS(N), .TICKS_PER_SEC(T), .ACK_TIMEOUT_S(A)) dut (
    .CLOCK_50(clk), .reset(reset), .set_time(set_time), .set_hours(set_hours),
    .set_minutes(set_minutes), .set_seconds(set_seconds), .cfg_we(cfg_we),
    .cfg_slot(cfg_slot), .cfg_hours(cfg_hours), .cfg_minutes(cfg_minutes),
    .cfg_enable(cfg_enable), .disp_ack(disp_ack), .missed_clr(missed_clr),
    .hours(hours), .minutes(minutes), .seconds(seconds), .second_pulse(second_pulse),
    .disp_req(disp_req), .disp_slot(disp_slot), .pending(pending), .missed(missed),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: time as seconds of day; m_serv is the slot being served (-1 none).
  int m_tod, m_presc, m_serv, m_to, m_slot;
  bit m_run, m_tick, m_done;
  int s_hh [N];
  int s_mm [N];
  bit s_en [N];
  bit m_pend [N];
  bit m_miss [N];
  int n_vec, n_err, pulses_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [31:0] pack_bits(input bit b [N]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = b[i];
    return v;
  endfunction

  function automatic bit m_pulse();
    return m_run && !set_time && (m_presc == T - 1);
  endfunction

  task automatic model_reset();
    m_tod = 0; m_presc = 0; m_serv = -1; m_to = 0; m_slot = 0;
    m_run = 0; m_tick = 0; m_done = 0;
    for (int i = 0; i < N; i++) begin
      s_hh[i] = 0; s_mm[i] = 0; s_en[i] = 0; m_pend[i] = 0; m_miss[i] = 0;
    end
  endtask

  task automatic model_step();
    bit pulse, cfg_ok;
    bit match [N];
    bit dis [N];
    bit fclr [N];
    bit fmiss [N];
    int pick;
    pulse  = m_pulse();
    cfg_ok = cfg_we && (cfg_slot < N) && (cfg_hours <= 23) && (cfg_minutes <= 59);
    for (int i = 0; i < N; i++) begin
      match[i] = m_tick && !set_time && s_en[i] && (m_tod % 60 == 0) &&
                 (m_tod / 3600 == s_hh[i]) && ((m_tod / 60) % 60 == s_mm[i]);
      dis[i]   = cfg_ok && !cfg_enable && (int'(cfg_slot) == i);
      fclr[i]  = 0;
      fmiss[i] = 0;
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_serv < 0) begin
      pick = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && !dis[i]) pick = i;
      if (pick >= 0) begin m_serv = pick; m_slot = pick; m_to = 0; end
    end else begin
      if (disp_ack || dis[m_serv]) begin
        fclr[m_serv] = 1; m_serv = -1; m_done = 1;
      end else if (pulse) begin
        m_to++;
        if (m_to == A) begin fclr[m_serv] = 1; fmiss[m_serv] = 1; m_serv = -1; m_done = 1; end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_miss[i] = fmiss[i] || (match[i] && m_pend[i]) || (m_miss[i] && !missed_clr[i]);
      m_pend[i] = (m_pend[i] && !fclr[i] && !dis[i]) || (match[i] && !dis[i]);
    end
    if (cfg_ok) begin
      s_hh[cfg_slot] = cfg_hours; s_mm[cfg_slot] = cfg_minutes; s_en[cfg_slot] = cfg_enable;
    end
    if (set_time) begin
      m_presc = 0;
      m_tod = clampi(set_hours, 23) * 3600 + clampi(set_minutes, 59) * 60 + clampi(set_seconds, 59);
    end else if (m_run) begin
      if (pulse) begin m_presc = 0; m_tod = (m_tod + 1) % 86400; end
      else m_presc++;
    end
    m_tick = pulse;
    m_run  = 1;
  endtask

  task automatic compare();
    check_eq("hours", hours, m_tod / 3600);
    check_eq("minutes", minutes, (m_tod / 60) % 60);
    check_eq("seconds", seconds, m_tod % 60);
    check_eq("second_pulse", second_pulse, m_pulse());
    check_eq("disp_req", disp_req, m_serv >= 0);
    check_eq("disp_slot", disp_slot, m_slot);
    check_eq("pending", pending, pack_bits(m_pend));
    check_eq("missed", missed, pack_bits(m_miss));
    check_eq("state_legal", dbg_state != 2'd3, 1);
    pulses_seen += second_pulse;
  endtask

  task automatic cycle();
    #1 compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    set_time = 0; cfg_we = 0; disp_ack = 0; missed_clr = '0;
  endtask

  task automatic do_time(input int h, input int m, input int s, input int n);
    set_time = 1; set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s);
    repeat (n) cycle();
    set_time = 0;
  endtask

  task automatic do_cfg(input int slot, input int h, input int m, input bit en);
    cfg_we = 1; cfg_slot = 2'(slot); cfg_hours = 5'(h); cfg_minutes = 6'(m); cfg_enable = en;
    cycle();
    cfg_we = 0;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!disp_req && k < 60) begin cycle(); k++; end
    check_eq(tag, disp_req, 1);
  endtask

  task automatic ack_once();
    disp_ack = 1; cycle(); disp_ack = 0;
  endtask

  task automatic run(input int n, input int ack_pct, input int clr_pct, input int cfg_pct);
    repeat (n) begin
      disp_ack   = ($urandom_range(0, 99) < ack_pct);
      missed_clr = ($urandom_range(0, 99) < clr_pct) ? 3'($urandom_range(0, 7)) : 3'b000;
      cfg_we     = ($urandom_range(0, 99) < cfg_pct);
      cfg_slot   = 2'($urandom_range(0, 3));
      cfg_hours  = 5'($urandom_range(0, 24));
      cfg_minutes = 6'($urandom_range(0, 60));
      cfg_enable = $urandom_range(0, 1);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, p0, t, ks;
    n_vec = 0; n_err = 0; pulses_seen = 0;
    reset = 0;
    idle_inputs();
    set_hours = '0; set_minutes = '0; set_seconds = '0;
    cfg_slot = '0; cfg_hours = '0; cfg_minutes = '0; cfg_enable = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 compare();
    @(negedge clk);
    reset = 1;

    // Release: prescaler first advances on the second edge, so the pulse comes after 4 cycles.
    repeat (4) cycle();
    #1 check_eq("first_pulse", second_pulse, 1);

    // Midnight wrap
    do_time(23, 59, 58, 1);
    p0 = pulses_seen;
    repeat (8) cycle();
    check_eq("wrap_time", {hours, minutes, seconds}, 0);
    check_eq("wrap_pulses", pulses_seen - p0, 2);

    // Rejected config writes leave slot 0 at 08:00
    do_cfg(0, 8, 0, 1);
    do_cfg(3, 7, 0, 1);
    do_cfg(0, 7, 60, 1);
    do_time(7, 59, 59, 1);
    k = 0;
    while (!pending[0] && k < 40) begin cycle(); k++; end
    check_eq("match_pending", pending[0], 1);
    check_eq("pre_req", disp_req, 0);
    cycle();
    check_eq("req_latency", disp_req, 1);
    check_eq("req_slot", disp_slot, 0);
    ack_once();
    check_eq("done_req", disp_req, 0);
    check_eq("ack_pending", pending[0], 0);
    cycle();
    check_eq("idle_req", disp_req, 0);

    // Two slots at the same time: lowest index first
    do_cfg(0, 13, 0, 1);
    do_cfg(1, 0, 0, 0);
    do_cfg(2, 13, 0, 1);
    do_time(12, 59, 58, 1);
    wait_req("wait_first");
    check_eq("first_slot", disp_slot, 0);
    repeat (2) cycle();
    ack_once();
    wait_req("wait_second");
    check_eq("second_slot", disp_slot, 2);
    ack_once();
    repeat (2) cycle();
    check_eq("dual_missed", missed, 0);

    // Timeout
    do_cfg(0, 15, 0, 1);
    do_time(14, 59, 59, 1);
    wait_req("wait_to");
    k = 0;
    while (disp_req && k < 40) begin cycle(); k++; end
    check_eq("timeout_drop", disp_req, 0);
    check_eq("timeout_missed", missed[0], 1);
    missed_clr = 3'b001; cycle(); missed_clr = '0;
    check_eq("missed_clr", missed[0], 0);

    // Asynchronous reset while requesting
    do_cfg(1, 6, 30, 1);
    do_time(6, 29, 59, 1);
    wait_req("wait_rst");
    #2 reset = 0;
    #1;
    check_eq("rst_req", disp_req, 0);
    check_eq("rst_time", {hours, minutes, seconds}, 0);
    check_eq("rst_flags", {pending, missed}, 0);
    check_eq("rst_slot", disp_slot, 0);
    check_eq("rst_pulse", second_pulse, 0);
    model_reset();
    @(negedge clk);
    reset = 1;
    do_cfg(1, 7, 0, 1);
    do_time(6, 59, 59, 1);
    wait_req("wait_after_rst");
    check_eq("after_rst_slot", disp_slot, 1);
    ack_once();

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      repeat (2) begin
        cfg_we = 1;
        cfg_slot = 2'($urandom_range(0, 3));
        cfg_hours = 5'($urandom_range(0, 24));
        cfg_minutes = 6'($urandom_range(0, 60));
        cfg_enable = ($urandom_range(0, 3) != 0);
        cycle();
        cfg_we = 0;
      end
      if (r % 5 == 0) begin
        do_time(31, 63, 63, 1);
        repeat (2) cycle();
      end
      ks = $urandom_range(0, N - 1);
      t = (s_hh[ks] * 3600 + s_mm[ks] * 60 - $urandom_range(1, 2) + 86400) % 86400;
      do_time(t / 3600, (t / 60) % 60, t % 60, $urandom_range(1, 3));
      run(45, $urandom_range(0, 40), 5, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
